// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile_sb register file / scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_AW   = $clog2(DEF_NREG);

  typedef logic signed [DEF_XLEN-1:0] xword_t;
  typedef logic        [DEF_AW-1:0]   ridx_t;

  localparam ridx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/execute-facing bus of regfile_sb: read ports, issue handshake, writeback.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic        [AW-1:0]   rs1;
  logic        [AW-1:0]   rs2;
  logic signed [XLEN-1:0] rdata1;
  logic signed [XLEN-1:0] rdata2;
  logic                   busy1;
  logic                   busy2;
  logic                   iss_valid;
  logic        [AW-1:0]   iss_rd;
  logic                   iss_ready;
  logic                   wb_valid;
  logic        [AW-1:0]   wb_rd;
  logic signed [XLEN-1:0] wb_data;
  logic        [AW:0]     busy_cnt;

  modport master (
    output rs1, rs2, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
    input  rdata1, rdata2, busy1, busy2, iss_ready, busy_cnt
  );

  modport slave (
    input  rs1, rs2, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
    output rdata1, rdata2, busy1, busy2, iss_ready, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy bitmap for in-flight destinations: issue sets, writeback clears, issue wins on a tie.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = DEF_NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic            iss_ready,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     busy_cnt
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt;

  // A pending writeback to the same register frees it in time for this issue.
  assign iss_ready = (iss_rd == AW'(ZERO_REG)) ||
                     !(busy_q[iss_rd] && !(wb_valid && wb_rd == iss_rd));

  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    busy_nxt = busy_q;
    if (wb_valid)
      busy_nxt[wb_rd] = 1'b0;
    if (iss_valid && iss_ready)
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREG; i++)
      cnt = cnt + (AW+1)'(busy_q[i]);
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt;

endmodule

// File: rtl/regfile_sb.sv
// Register file with integrated scoreboard; x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward writeback data/busy-clear to the read ports in the same cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = DEF_XLEN,
  parameter  int NREG = DEF_NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic            wr_en;

  assign wr_en = bus.wb_valid && (bus.wb_rd != AW'(ZERO_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is reset on purpose; reset must read back zeros from every register.
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wr_en) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .wb_valid  (bus.wb_valid),
    .wb_rd     (bus.wb_rd),
    .iss_ready (bus.iss_ready),
    .busy      (busy),
    .busy_cnt  (bus.busy_cnt)
  );

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  // rst_n gating keeps a writeback coincident with reset from leaking onto the read ports.
  assign hit1 = rst_n && wr_en && (bus.wb_rd == bus.rs1);
  assign hit2 = rst_n && wr_en && (bus.wb_rd == bus.rs2);

  assign bus.rdata1 = hit1 ? bus.wb_data : rf[bus.rs1];
  assign bus.rdata2 = hit2 ? bus.wb_data : rf[bus.rs2];
  assign bus.busy1  = busy[bus.rs1] && !hit1;
  assign bus.busy2  = busy[bus.rs2] && !hit2;
`else
  assign bus.rdata1 = rf[bus.rs1];
  assign bus.rdata2 = rf[bus.rs2];
  assign bus.busy1  = busy[bus.rs1];
  assign bus.busy2  = busy[bus.rs2];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  regfile_sb_if #(.XLEN(32), .NREG(32)) bus ();

  regfile_sb #(.XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.wb_valid  = 1'b0;
  endtask

  initial begin
    xword_t d_beef;
    xword_t d_byp;
    n_pass  = 0;
    n_total = 0;
    d_beef  = 32'hDEADBEEF;
    d_byp   = 32'h55;

    // Reset state
    rst_n         = 1'b0;
    bus.rs1       = 5'd5;
    bus.rs2       = 5'd31;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = 5'd0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = '0;
    #3;
    check("rst_rdata1", bus.rdata1, 32'h0);
    check("rst_rdata2", bus.rdata2, 32'h0);
    check("rst_busy1", 32'(bus.busy1), 32'd0);
    check("rst_busy2", 32'(bus.busy2), 32'd0);
    check("rst_busy_cnt", 32'(bus.busy_cnt), 32'd0);
    check("rst_iss_ready", 32'(bus.iss_ready), 32'd1);

    // Writeback during reset is ignored
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'hAA;
    #1;
    check("rst_wb_bypass", bus.rdata1, 32'h0);
    tick();
    check("rst_wb_ignored", bus.rdata1, 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Basic write/read
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    bus.wb_data  = d_beef;
    bus.rs1      = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr7_same_cycle", bus.rdata1, 32'hDEADBEEF);
`else
    check("wr7_same_cycle", bus.rdata1, 32'h0);
`endif
    tick();
    idle();
    #1;
    check("wr7_read", bus.rdata1, 32'hDEADBEEF);

    // Writes to x0 are discarded
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'h1234;
    bus.rs2      = 5'd0;
    #1;
    check("wr0_same_cycle", bus.rdata2, 32'h0);
    tick();
    idle();
    #1;
    check("wr0_read", bus.rdata2, 32'h0);

    // Scoreboard: issue, blocked re-issue, writeback clears
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    bus.rs1       = 5'd3;
    #1;
    check("iss3_ready", 32'(bus.iss_ready), 32'd1);
    check("iss3_busy_pre", 32'(bus.busy1), 32'd0);
    tick();
    #1;
    check("iss3_busy1", 32'(bus.busy1), 32'd1);
    check("iss3_cnt", 32'(bus.busy_cnt), 32'd1);
    check("iss3_reissue_ready", 32'(bus.iss_ready), 32'd0);
    idle();
    tick();
    check("iss3_cnt_hold", 32'(bus.busy_cnt), 32'd1);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'h33;
    tick();
    idle();
    #1;
    check("wb3_cnt", 32'(bus.busy_cnt), 32'd0);
    check("wb3_busy1", 32'(bus.busy1), 32'd0);
    check("wb3_rdata1", bus.rdata1, 32'h33);

    // Same-cycle issue and writeback to x4: issue wins
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd4;
    tick();
    bus.iss_valid = 1'b0;
    #1;
    check("iss4_blocked", 32'(bus.iss_ready), 32'd0);
    check("iss4_cnt", 32'(bus.busy_cnt), 32'd1);
    bus.iss_valid = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd4;
    bus.wb_data   = 32'h44;
    #1;
    check("iss4_wb_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    idle();
    bus.rs1 = 5'd4;
    #1;
    check("iss4_wb_busy1", 32'(bus.busy1), 32'd1);
    check("iss4_wb_rdata1", bus.rdata1, 32'h44);
    check("iss4_wb_cnt", 32'(bus.busy_cnt), 32'd1);

    // Issue x6 and writeback x4 in the same cycle: independent
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd6;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd4;
    bus.wb_data   = 32'h4444;
    tick();
    idle();
    bus.rs2 = 5'd6;
    #1;
    check("split_busy4", 32'(bus.busy1), 32'd0);
    check("split_busy6", 32'(bus.busy2), 32'd1);
    check("split_cnt", 32'(bus.busy_cnt), 32'd1);
    check("split_rdata4", bus.rdata1, 32'h4444);

    // Issue to x0 is always ready and never marks busy
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd0;
    #1;
    check("iss0_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    idle();
    bus.rs1 = 5'd0;
    #1;
    check("iss0_cnt", 32'(bus.busy_cnt), 32'd1);
    check("iss0_busy1", 32'(bus.busy1), 32'd0);

    // Writeback to a non-busy register, then bypass check on x9
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = 32'h11;
    tick();
    idle();
    bus.rs1 = 5'd9;
    #1;
    check("load9_rdata1", bus.rdata1, 32'h11);
    check("load9_cnt", 32'(bus.busy_cnt), 32'd1);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    tick();
    idle();
    #1;
    check("iss9_busy1", 32'(bus.busy1), 32'd1);
    check("iss9_cnt", 32'(bus.busy_cnt), 32'd2);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = d_byp;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp9_rdata1", bus.rdata1, 32'h55);
    check("byp9_busy1", 32'(bus.busy1), 32'd0);
`else
    check("byp9_rdata1", bus.rdata1, 32'h11);
    check("byp9_busy1", 32'(bus.busy1), 32'd1);
`endif
    check("byp9_iss_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    idle();
    #1;
    check("wb9_rdata1", bus.rdata1, 32'h55);
    check("wb9_busy1", 32'(bus.busy1), 32'd0);
    check("wb9_cnt", 32'(bus.busy_cnt), 32'd1);

    // Async reset mid-operation with five registers busy
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd2;
    bus.wb_data  = 32'h77;
    tick();
    idle();
    bus.iss_valid = 1'b1;
    for (int r = 10; r <= 13; r++) begin
      bus.iss_rd = ridx_t'(r);
      tick();
    end
    idle();
    bus.rs1 = 5'd2;
    #1;
    check("pre_rst_cnt", 32'(bus.busy_cnt), 32'd5);
    check("pre_rst_rdata2", bus.rdata1, 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cnt", 32'(bus.busy_cnt), 32'd0);
    check("mid_rst_rdata", bus.rdata1, 32'h0);
    check("mid_rst_busy6", 32'(bus.busy2), 32'd0);
    bus.iss_rd = 5'd10;
    #1;
    check("mid_rst_ready", 32'(bus.iss_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every register: busy_cnt reaches NREG-1
    bus.iss_valid = 1'b1;
    for (int r = 0; r < 32; r++) begin
      bus.iss_rd = ridx_t'(r);
      tick();
    end
    idle();
    #1;
    check("full_cnt", 32'(bus.busy_cnt), 32'd31);
    bus.iss_rd = 5'd31;
    #1;
    check("full_ready31", 32'(bus.iss_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated scoreboard. It replaces the combinational register array between decode and execute in the RV32 core. Writes are clocked and there is an optional write-to-read bypass. A per-register busy bitmap tracks in-flight destinations, so decode can stall on RAW and WAW hazards without a separate hazard unit.

## Interface

Parameters:
- `XLEN`, default 32: data width in bits.
- `NREG`, default 32: number of architectural registers; must be a power of two, ≥ 2.
- `AW`, default `$clog2(NREG)`: register index width; derived, not overridden.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rs1`, input, AW: read port 1 index.
- `rs2`, input, AW: read port 2 index.
- `rdata1`, output, XLEN: read port 1 data, signed.
- `rdata2`, output, XLEN: read port 2 data, signed.
- `busy1`, output, 1: `rs1` has a write pending.
- `busy2`, output, 1: `rs2` has a write pending.
- `iss_valid`, input, 1: decode requests issue of an instruction that writes `iss_rd`.
- `iss_rd`, input, AW: destination of the issuing instruction.
- `iss_ready`, output, 1: issue is accepted this cycle.
- `wb_valid`, input, 1: writeback strobe.
- `wb_rd`, input, AW: writeback destination.
- `wb_data`, input, XLEN: writeback data.
- `busy_cnt`, output, AW+1: number of registers currently busy.

## Operation

- Storage: `NREG` × `XLEN` flops. Register 0 is hardwired to 0.
  - Writes to index 0 are discarded.
  - Index 0 is never busy.
- Reads are combinational. `rdataN = rf[rsN]`, subject to bypass (see Configuration).
- Write: on the rising edge with `wb_valid=1` and `wb_rd≠0`, `rf[wb_rd] ← wb_data`, and `busy[wb_rd]` is cleared.
- Issue handshake:
  - `iss_ready = !(busy[iss_rd] && !(wb_valid && wb_rd==iss_rd))`, or 1 when `iss_rd==0`.
  - An issue is accepted on the edge where `iss_valid && iss_ready`. It sets `busy[iss_rd]` (no effect for index 0).
  - `iss_ready` is valid regardless of `iss_valid`, so decode may sample it early.
- Simultaneous issue and writeback to the same nonzero register: the data is written and `busy` ends **set**. Issue wins.
- Simultaneous issue and writeback to different registers: both take effect independently.
- Writeback to a register that is not busy: data is written and busy stays 0. This is legal; it covers the initial-load path.
- Hazard flags: `busyN = busy[rsN]`, masked as described under Configuration.
- `busy_cnt` is the popcount of the registered busy bitmap. Range 0…NREG−1.

## Timing

- Reset (`rst_n` low, asynchronous): all `rf` entries are 0 and all busy bits are 0.
  - Outputs during reset: `rdata1/2=0`, `busy1/2=0`, `iss_ready=1`, `busy_cnt=0`.
  - Deassertion is synchronised externally. Assertion mid-operation aborts all pending writes; a `wb_valid` coincident with reset is ignored.
- Write latency: data written at edge N is visible combinationally on `rdataN` after edge N. With bypass enabled it is visible in the same cycle as `wb_valid`.
- Busy set latency: 1 edge. A register issued at edge N reads `busy=1` from cycle N+1.
- Busy clear latency: 1 edge, or 0 cycles on `busyN` with bypass enabled.
- No internal state machine beyond the bitmap. There are no multi-cycle operations.

## Configuration

Macro `REGFILE_BYPASS_EN`.

Defined:
- If `wb_valid && wb_rd==rsN && rsN≠0`, then `rdataN=wb_data` and `busyN=0` in that cycle.
- Execute may consume a register in the same cycle it is written back.

Undefined:
- `rdataN` is always the stored value.
- `busyN` reflects only the registered bitmap.
- A consumer waits one extra cycle after writeback.
- `iss_ready` behaviour is identical in both builds.

## Structure

- Package `regfile_pkg`:
  - typedef `xword_t` (logic signed [XLEN-1:0]);
  - typedef `ridx_t` (logic [AW-1:0]);
  - localparam `ZERO_REG = '0`.
- Sub-module `rf_scoreboard`:
  - holds the busy bitmap, issue/writeback set/clear logic, `iss_ready` and `busy_cnt`;
  - shares `clk`/`rst_n`.
- The data array and bypass muxes stay in the top level.

## Test plan

- **Reset:** hold `rst_n=0` and read `rs1=5`, `rs2=31` → `rdata=0`, `busy=0`, `busy_cnt=0`, `iss_ready=1`.
- **Basic write/read:** write `wb_rd=7`, `wb_data=0xDEADBEEF`; read `rs1=7` the next cycle → `0xDEADBEEF`. Write `rd=0` with `0x1234` → `rs2=0` reads 0.
- **Scoreboard:** issue `rd=3` → `busy1=1` for `rs1=3`, `busy_cnt=1`. A second issue to `rd=3` → `iss_ready=0`. Writeback `rd=3` → `busy_cnt=0`.
- **Same-cycle issue and writeback to `rd=4`** (4 busy) → `iss_ready=1`; after the edge `busy[4]=1` and `rf[4]=wb_data`.
- **Bypass, `REGFILE_BYPASS_EN`:** with 9 busy, `wb_valid`, `wb_rd=9`, `wb_data=0x55`, `rs1=9` → same cycle `rdata1=0x55`, `busy1=0`. Without the macro → old value and `busy1=1`.
- **Async reset mid-operation:** 5 registers busy and `rf[2]=0x77`, then drop `rst_n` between edges → immediately `busy_cnt=0` and `rf[2]` reads 0.
